dma_io_peripheral: RTL and testbench
====================================

Name: dma_io_peripheral

Overview:
Bus-side model of an I/O device that requests DMA service from the 8237-style DMA controller. It is the other end of the DREQ/DACK/IOR_N/IOW_N/EOP_N handshake. The device raises DREQ and, while DACK is active, either drives DB during IOR_N (device-to-memory) or captures DB on IOW_N (memory-to-device). An internal FIFO buffers data toward or from a local streaming interface. It serves as the DMA controller's channel stimulus in simulation and as the reusable device-side DMA front end.

Parameters:
DEPTH, 8, FIFO entries; power of two, at least 2
CNT_W, 16, width of the transfer counter

Ports:
CLK  in  1  clock; all logic on rising edge
RESET_N  in  1  synchronous active-low reset
DACK  in  1  DMA acknowledge for this channel, active high
IOR_N  in  1  I/O read strobe from the DMA controller, active low
IOW_N  in  1  I/O write strobe from the DMA controller, active low
EOP_N  in  1  end of process, active low
DB_IN  in  8  data bus input
DB_OUT  out  8  data bus output
DB_OE  out  1  data bus output enable
DREQ  out  1  DMA request
mode  in  1  0 = source (device to memory, IOR_N cycles); 1 = sink (memory to device, IOW_N cycles)
enable  in  1  allows requests
src_valid / src_data[7:0] / src_ready  in/in/out  local push side; used in source mode
snk_valid / snk_data[7:0] / snk_ready  out/out/in  local pop side; used in sink mode
xfer_count  out  CNT_W  bytes moved since enable rose; wraps
done  out  1  sticky; set by EOP
overrun  out  1  sticky; set by a sink strobe while the FIFO is full
underrun  out  1  sticky; set by a source strobe while the FIFO is empty

Behaviour:
- Reset (RESET_N=0 at a clock edge) gives:
  - DREQ=0, DB_OE=0, DB_OUT=0
  - FIFO empty; xfer_count=0; done, overrun, underrun all 0
  - state=IDLE; strobe history registers=1
  - Reset mid-transfer aborts the transfer immediately and the FIFO contents are lost.
- Ready condition "rdy": source mode = FIFO not empty; sink mode = FIFO not full.
- mode is latched on the IDLE to REQ transition. Changes to mode outside IDLE are ignored.
- Strobe completion, per cycle:
  - source: DACK=1, previous IOR_N=0, current IOR_N=1
  - sink: DACK=1, previous IOW_N=0, current IOW_N=1
- States:
  - IDLE: DREQ=0. If enable and rdy and DACK=0, go to REQ.
  - REQ: DREQ=1 (registered, so it asserts the cycle after entry). DACK=1 goes to ACK. If enable drops, go to IDLE.
  - ACK: DREQ=1. Possible outcomes:
    - Strobe completion with EOP seen: go to DONE.
    - Strobe completion, enable=1 and rdy still true: stay in ACK (demand-mode continuation).
    - Strobe completion otherwise: go to REL.
    - DACK falls with no strobe completion: go to REQ if enable and rdy, else IDLE.
  - REL: DREQ=0. When DACK=0, go to IDLE.
  - DONE: DREQ=0, done=1. When enable=0, go to IDLE. done clears when enable rises again.
- EOP seen: EOP_N sampled 0 while DACK=1 in ACK, latched until strobe completion or exit from ACK. EOP_N low while DACK=0 is ignored.
- Source data path:
  - DB_OE = state==ACK & DACK & !IOR_N & mode==0 (combinational).
  - DB_OUT = FIFO head while DB_OE=1, else 0.
  - Strobe completion pops one entry and increments xfer_count.
  - Pop while empty sets underrun; xfer_count still increments.
- Sink data path:
  - DB_IN is registered every cycle that DACK & !IOW_N.
  - Strobe completion pushes that registered byte and increments xfer_count.
  - Push while full drops the byte and sets overrun.
- Local side:
  - src_ready = !full.
  - snk_valid = !empty; snk_data = FIFO head.
  - A bus pop or push and a local push or pop in the same cycle leave the level unchanged. This holds at full and at empty.
- xfer_count clears on the rising edge of enable and wraps at 2^CNT_W with no flag.
- Dropping enable mid-transfer: from ACK, go to REL on the next strobe completion or on DACK fall. A strobe already in progress completes normally.
- Latency: strobe completion updates the FIFO pointer and xfer_count on the following edge. DREQ is always registered.

Test Plan:
1. Source: push A5,3C; enable=1 -> DREQ=1 in 2 cycles. DACK=1, IOR_N low for 2 cycles -> DB_OE=1, DB_OUT=A5. IOR_N rise -> pop; next byte 3C; xfer_count=2; after the FIFO empties, REL and DREQ=0.
2. Sink: DEPTH=8. DMA writes 8 bytes 00..07 via IOW_N in demand mode -> DREQ drops after the 8th byte (full). Local pop order is 00..07.
3. Ninth IOW_N strobe at full, byte FF -> overrun=1, FF is not stored, xfer_count=9.
4. EOP_N=0 during the third of 5 source strobes -> done=1, DREQ=0, xfer_count=3. done stays set until enable toggles.
5. DACK falls before IOR_N rises -> no pop, state returns to REQ, DREQ stays 1. Simultaneous local push and bus pop at full -> level stays 8.
6. RESET_N=0 mid-ACK with DB_OE=1 -> next edge DB_OE=0, DREQ=0, FIFO empty, xfer_count=0, flags cleared.

Source files
------------

// File: rtl/dma_io_peripheral.sv
// Device-side DMA front end for an 8237-style controller.
// Raises DREQ while the local FIFO can serve a transfer. While DACK is high it
// drives DB during IOR_N (source mode) or captures DB on IOW_N (sink mode).
// A strobe completes on the cycle where the strobe is seen high again after
// being low.
module dma_io_peripheral #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             DACK,
  input  logic             IOR_N,
  input  logic             IOW_N,
  input  logic             EOP_N,
  input  logic [7:0]       DB_IN,
  output logic [7:0]       DB_OUT,
  output logic             DB_OE,
  output logic             DREQ,
  input  logic             mode,
  input  logic             enable,
  input  logic             src_valid,
  input  logic [7:0]       src_data,
  output logic             src_ready,
  output logic             snk_valid,
  output logic [7:0]       snk_data,
  input  logic             snk_ready,
  output logic [CNT_W-1:0] xfer_count,
  output logic             done,
  output logic             overrun,
  output logic             underrun
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LVL_ZERO = (AW+1)'(0);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_ACK  = 3'd2,
    ST_REL  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic             r_mode;
  logic             r_ior_prev;
  logic             r_iow_prev;
  logic             r_en_prev;
  logic             r_eop;
  logic             r_dreq;
  logic             r_done;
  logic             r_overrun;
  logic             r_underrun;
  logic [7:0]       r_db_in;
  logic [7:0]       r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic [CNT_W-1:0] r_xfer_count;

  logic        w_empty;
  logic        w_full;
  logic        w_strobe;
  logic        w_bus_pop;
  logic        w_bus_push;
  logic        w_loc_push;
  logic        w_loc_pop;
  logic        w_do_push;
  logic        w_do_pop;
  logic [7:0]  w_push_data;
  logic [AW:0] w_level_next;
  logic        w_rdy_idle;
  logic        w_rdy_now;
  logic        w_rdy_after;
  logic        w_eop_seen;
  logic        w_en_rise;
  logic        w_dreq_d;
  logic        w_done_set;
  logic        w_db_oe;

  assign w_empty   = (r_level == LVL_ZERO);
  assign w_full    = (r_level == LVL_FULL);
  assign w_en_rise = enable & ~r_en_prev;

  // A completed strobe only counts once the channel has left IDLE.
  assign w_strobe = DACK & (r_state != ST_IDLE) &
                    (r_mode ? (~r_iow_prev & IOW_N) : (~r_ior_prev & IOR_N));
  assign w_bus_pop  = w_strobe & ~r_mode;
  assign w_bus_push = w_strobe & r_mode;

  // Local traffic may pass through a full or empty FIFO when the bus side
  // frees or fills the slot in the same cycle; the bus wins any port clash.
  assign w_loc_push  = src_valid & (~w_full | w_bus_pop) & ~w_bus_push;
  assign w_loc_pop   = snk_ready & (~w_empty | w_bus_push) & ~w_bus_pop;
  assign w_do_push   = (w_bus_push | w_loc_push) & (~w_full | w_bus_pop | w_loc_pop);
  assign w_do_pop    = (w_bus_pop | w_loc_pop) & (~w_empty | w_bus_push | w_loc_push);
  assign w_push_data = w_bus_push ? r_db_in : src_data;

  // FIFO occupancy after this cycle's push/pop.
  always_comb begin
    w_level_next = r_level;
    case ({w_do_push, w_do_pop})
      2'b10:   w_level_next = r_level + (AW+1)'(1);
      2'b01:   w_level_next = r_level - (AW+1)'(1);
      default: w_level_next = r_level;
    endcase
  end

  assign w_rdy_idle  = mode ? ~w_full : ~w_empty;
  assign w_rdy_now   = r_mode ? ~w_full : ~w_empty;
  assign w_rdy_after = r_mode ? (w_level_next != LVL_FULL) : (w_level_next != LVL_ZERO);
  assign w_eop_seen  = r_eop | (DACK & ~EOP_N);

  // State register.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic of the DREQ/DACK handshake.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (enable && w_rdy_idle && !DACK) w_state_next = ST_REQ;
        else                               w_state_next = ST_IDLE;
      end
      ST_REQ: begin
        if (!enable)   w_state_next = ST_IDLE;
        else if (DACK) w_state_next = ST_ACK;
        else           w_state_next = ST_REQ;
      end
      ST_ACK: begin
        if (w_strobe) begin
          if (w_eop_seen)                w_state_next = ST_DONE;
          else if (enable && w_rdy_after) w_state_next = ST_ACK;
          else                           w_state_next = ST_REL;
        end else if (!DACK) begin
          if (!enable)        w_state_next = ST_REL;
          else if (w_rdy_now) w_state_next = ST_REQ;
          else                w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_ACK;
        end
      end
      ST_REL: begin
        if (!DACK) w_state_next = ST_IDLE;
        else       w_state_next = ST_REL;
      end
      ST_DONE: begin
        if (!enable) w_state_next = ST_IDLE;
        else         w_state_next = ST_DONE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Per-state outputs: request level, done trigger and bus drive enable.
  always_comb begin
    w_dreq_d   = (r_state == ST_REQ) || (r_state == ST_ACK);
    w_done_set = (r_state == ST_ACK) && (w_state_next == ST_DONE);
    w_db_oe    = (r_state == ST_ACK) && DACK && !IOR_N && !r_mode;
  end

  // Control registers: strobe history, mode latch, EOP latch, DREQ, flags, counter.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_ior_prev   <= 1'b1;
      r_iow_prev   <= 1'b1;
      r_en_prev    <= 1'b0;
      r_mode       <= 1'b0;
      r_eop        <= 1'b0;
      r_dreq       <= 1'b0;
      r_done       <= 1'b0;
      r_overrun    <= 1'b0;
      r_underrun   <= 1'b0;
      r_db_in      <= 8'h00;
      r_xfer_count <= {CNT_W{1'b0}};
    end else begin
      r_ior_prev <= IOR_N;
      r_iow_prev <= IOW_N;
      r_en_prev  <= enable;
      r_dreq     <= w_dreq_d;
      if (r_state == ST_IDLE && w_state_next == ST_REQ) r_mode <= mode;
      // EOP is held only while the channel stays in ACK without completing.
      if (r_state == ST_ACK && w_state_next == ST_ACK && !w_strobe) r_eop <= w_eop_seen;
      else                                                           r_eop <= 1'b0;
      if (DACK && !IOW_N) r_db_in <= DB_IN;
      if (w_en_rise)       r_done <= 1'b0;
      else if (w_done_set) r_done <= 1'b1;
      if (w_bus_push && !w_do_push) r_overrun <= 1'b1;
      if (w_bus_pop && w_empty)     r_underrun <= 1'b1;
      if (w_en_rise)     r_xfer_count <= {CNT_W{1'b0}};
      else if (w_strobe) r_xfer_count <= r_xfer_count + CNT_W'(1);
    end
  end

  // FIFO pointers and occupancy; reset discards the contents.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_level  <= LVL_ZERO;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= w_level_next;
    end
  end

  // FIFO storage; no reset needed since the pointers define validity.
  always_ff @(posedge CLK) begin
    if (w_do_push) r_mem[r_wr_ptr] <= w_push_data;
  end

  assign DREQ       = r_dreq;
  assign DB_OE      = w_db_oe;
  assign DB_OUT     = w_db_oe ? r_mem[r_rd_ptr] : 8'h00;
  assign src_ready  = ~w_full;
  assign snk_valid  = ~w_empty;
  assign snk_data   = r_mem[r_rd_ptr];
  assign xfer_count = r_xfer_count;
  assign done       = r_done;
  assign overrun    = r_overrun;
  assign underrun   = r_underrun;

endmodule

// File: tb/tb_dma_io_peripheral.sv
// Directed bench for dma_io_peripheral: a vector table for the sink-mode fill
// to full and overrun, plus hand sequences for source, EOP, DACK abort and reset.
module tb_dma_io_peripheral;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        DACK, IOR_N, IOW_N, EOP_N;
  logic [7:0]  DB_IN, DB_OUT;
  logic        DB_OE, DREQ;
  logic        mode, enable;
  logic        src_valid, src_ready;
  logic [7:0]  src_data;
  logic        snk_valid, snk_ready;
  logic [7:0]  snk_data;
  logic [15:0] xfer_count;
  logic        done, overrun, underrun;

  int total = 0;
  int bad   = 0;

  dma_io_peripheral #(.DEPTH(8), .CNT_W(16)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .DACK(DACK), .IOR_N(IOR_N), .IOW_N(IOW_N),
    .EOP_N(EOP_N), .DB_IN(DB_IN), .DB_OUT(DB_OUT), .DB_OE(DB_OE), .DREQ(DREQ),
    .mode(mode), .enable(enable), .src_valid(src_valid), .src_data(src_data),
    .src_ready(src_ready), .snk_valid(snk_valid), .snk_data(snk_data),
    .snk_ready(snk_ready), .xfer_count(xfer_count), .done(done),
    .overrun(overrun), .underrun(underrun)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       dack;
    logic       iow_n;
    logic [7:0] db;
    logic       exp_dreq;
    int         exp_cnt;
    logic       exp_ovr;
    logic       exp_srdy;
  } vec_t;

  vec_t tbl [18];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    DACK = 1'b0; IOR_N = 1'b1; IOW_N = 1'b1; EOP_N = 1'b1; DB_IN = 8'h00;
    mode = 1'b0; enable = 1'b0; src_valid = 1'b0; src_data = 8'h00; snk_ready = 1'b0;
    tick();
    RESET_N = 1'b1;
  endtask

  task automatic push(input logic [7:0] d);
    src_valid = 1'b1; src_data = d;
    tick();
    src_valid = 1'b0;
  endtask

  task automatic drain_check(input string name, input int first, input int n);
    for (int i = 0; i < n; i++) begin
      #1;
      chk({name, "_valid"}, snk_valid, 1);
      chk({name, "_data"}, snk_data, (first + i) & 8'hFF);
      snk_ready = 1'b1;
      tick();
      snk_ready = 1'b0;
    end
    #1;
    chk({name, "_empty"}, snk_valid, 0);
  endtask

  initial begin
    // Sink vectors: 8 bytes 00..07 fill the FIFO, 9th byte FF overruns.
    for (int k = 0; k < 9; k++) begin
      tbl[2*k].dack       = 1'b1;
      tbl[2*k].iow_n      = 1'b0;
      tbl[2*k].db         = (k == 8) ? 8'hFF : 8'(k);
      tbl[2*k].exp_dreq   = (k < 8);
      tbl[2*k].exp_cnt    = k;
      tbl[2*k].exp_ovr    = 1'b0;
      tbl[2*k].exp_srdy   = (k < 8);
      tbl[2*k+1].dack     = 1'b1;
      tbl[2*k+1].iow_n    = 1'b1;
      tbl[2*k+1].db       = tbl[2*k].db;
      tbl[2*k+1].exp_dreq = (k < 8);
      tbl[2*k+1].exp_cnt  = k + 1;
      tbl[2*k+1].exp_ovr  = (k == 8);
      tbl[2*k+1].exp_srdy = (k + 1 < 8);
    end

    // Reset state.
    do_reset();
    chk("rst_dreq", DREQ, 0);
    chk("rst_oe", DB_OE, 0);
    chk("rst_dbout", DB_OUT, 0);
    chk("rst_cnt", xfer_count, 0);
    chk("rst_done", done, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_udr", underrun, 0);
    chk("rst_snkv", snk_valid, 0);
    chk("rst_srdy", src_ready, 1);

    // Source transfer of two bytes, then a strobe on the empty FIFO.
    push(8'hA5);
    push(8'h3C);
    enable = 1'b1;
    tick();
    chk("t1_dreq_early", DREQ, 0);
    tick();
    chk("t1_dreq", DREQ, 1);
    DACK = 1'b1;
    tick();
    IOR_N = 1'b0;
    #1;
    chk("t1_oe", DB_OE, 1);
    chk("t1_db0", DB_OUT, 8'hA5);
    tick();
    tick();
    chk("t1_db0_hold", DB_OUT, 8'hA5);
    chk("t1_cnt0", xfer_count, 0);
    IOR_N = 1'b1;
    #1;
    chk("t1_oe_off", DB_OE, 0);
    tick();
    chk("t1_cnt1", xfer_count, 1);
    IOR_N = 1'b0;
    #1;
    chk("t1_db1", DB_OUT, 8'h3C);
    tick();
    IOR_N = 1'b1;
    tick();
    chk("t1_cnt2", xfer_count, 2);
    IOR_N = 1'b0;
    tick();
    chk("t1_rel_dreq", DREQ, 0);
    chk("t1_rel_oe", DB_OE, 0);
    chk("t1_no_udr", underrun, 0);
    IOR_N = 1'b1;
    tick();
    chk("t1_udr", underrun, 1);
    chk("t1_cnt3", xfer_count, 3);
    DACK = 1'b0;
    tick();
    tick();
    chk("t1_idle_dreq", DREQ, 0);

    // Sink fill to full in demand mode, then overrun (table driven).
    do_reset();
    mode = 1'b1;
    enable = 1'b1;
    tick();
    tick();
    chk("t2_dreq", DREQ, 1);
    DACK = 1'b1;
    tick();
    for (int r = 0; r < 18; r++) begin
      DACK = tbl[r].dack; IOW_N = tbl[r].iow_n; DB_IN = tbl[r].db;
      tick();
      chk($sformatf("t2_dreq_r%0d", r), DREQ, tbl[r].exp_dreq);
      chk($sformatf("t2_cnt_r%0d", r), xfer_count, tbl[r].exp_cnt);
      chk($sformatf("t2_ovr_r%0d", r), overrun, tbl[r].exp_ovr);
      chk($sformatf("t2_srdy_r%0d", r), src_ready, tbl[r].exp_srdy);
    end
    DACK = 1'b0;
    enable = 1'b0;
    tick();
    drain_check("t2_pop", 0, 8);

    // Reset mid-ACK while DB is driven; overrun from above must clear.
    mode = 1'b0;
    push(8'h30);
    push(8'h31);
    enable = 1'b1;
    tick();
    tick();
    DACK = 1'b1;
    tick();
    IOR_N = 1'b0;
    #1;
    chk("t6_oe_pre", DB_OE, 1);
    chk("t6_ovr_pre", overrun, 1);
    RESET_N = 1'b0;
    tick();
    chk("t6_oe", DB_OE, 0);
    chk("t6_dreq", DREQ, 0);
    chk("t6_cnt", xfer_count, 0);
    chk("t6_empty", snk_valid, 0);
    chk("t6_srdy", src_ready, 1);
    chk("t6_ovr", overrun, 0);
    chk("t6_done", done, 0);
    RESET_N = 1'b1;
    DACK = 1'b0;
    IOR_N = 1'b1;
    tick();

    // EOP on the third of five source strobes; EOP with DACK low ignored.
    do_reset();
    for (int i = 0; i < 5; i++) push(8'(8'h10 + i));
    enable = 1'b1;
    tick();
    EOP_N = 1'b0;
    tick();
    EOP_N = 1'b1;
    DACK = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      IOR_N = 1'b0;
      if (i == 2) EOP_N = 1'b0;
      #1;
      chk($sformatf("t4_db%0d", i), DB_OUT, 8'h10 + i);
      tick();
      IOR_N = 1'b1;
      EOP_N = 1'b1;
      tick();
      if (i == 0) chk("t4_no_done", done, 0);
    end
    chk("t4_done", done, 1);
    chk("t4_cnt", xfer_count, 3);
    tick();
    chk("t4_dreq", DREQ, 0);
    DACK = 1'b0;
    tick();
    tick();
    chk("t4_done_hold", done, 1);
    chk("t4_dreq_hold", DREQ, 0);
    enable = 1'b0;
    tick();
    chk("t4_done_en0", done, 1);
    enable = 1'b1;
    tick();
    chk("t4_done_clr", done, 0);
    chk("t4_cnt_clr", xfer_count, 0);

    // DACK falls before IOR_N rises, then pass-through push/pop at full.
    do_reset();
    for (int i = 0; i < 8; i++) push(8'(8'h20 + i));
    chk("t5_full", src_ready, 0);
    enable = 1'b1;
    tick();
    tick();
    chk("t5_dreq", DREQ, 1);
    DACK = 1'b1;
    tick();
    IOR_N = 1'b0;
    tick();
    DACK = 1'b0;
    tick();
    IOR_N = 1'b1;
    tick();
    chk("t5_nopop_cnt", xfer_count, 0);
    chk("t5_dreq_kept", DREQ, 1);
    chk("t5_still_full", src_ready, 0);
    DACK = 1'b1;
    tick();
    IOR_N = 1'b0;
    #1;
    chk("t5_oe", DB_OE, 1);
    chk("t5_head", DB_OUT, 8'h20);
    tick();
    IOR_N = 1'b1;
    src_valid = 1'b1;
    src_data = 8'h28;
    tick();
    src_valid = 1'b0;
    chk("t5_level8", src_ready, 0);
    chk("t5_cnt1", xfer_count, 1);
    chk("t5_udr", underrun, 0);
    DACK = 1'b0;
    enable = 1'b0;
    tick();
    drain_check("t5_pop", 8'h21, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
